analog_stick_calibrator: RTL and testbench

Calibrating analog-stick-to-DPAD controller for the Pocket input path. It sits between the per-player analog joystick bytes and the core's DPAD inputs. After the pad becomes analog, it waits for the stick to settle and learns the true rest center of all four axes by averaging. It then generates DPAD directions from the learned centers with deadzone, hysteresis and opposing-direction (SOCD) neutralisation.

---
 rtl/analog_stick_calibrator_if.sv | 26 ++
 rtl/analog_stick_calibrator.sv | 171 +++++++++++++++++
 tb/tb_analog_stick_calibrator.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/analog_stick_calibrator_if.sv
// Controller-side bundle for the analog stick calibrator: pad type, stick samples,
// recalibration request, and the resulting DPAD / busy outputs.
interface analog_stick_calibrator_if;
    logic [3:0] pad_type;
    logic       sample_stb;
    logic [7:0] joy_lx;
    logic [7:0] joy_ly;
    logic [7:0] joy_rx;
    logic [7:0] joy_ry;
    logic       recal;
    logic       cal_busy;
    logic       joy_up;
    logic       joy_down;
    logic       joy_left;
    logic       joy_right;

    modport master (
        output pad_type, sample_stb, joy_lx, joy_ly, joy_rx, joy_ry, recal,
        input  cal_busy, joy_up, joy_down, joy_left, joy_right
    );

    modport slave (
        input  pad_type, sample_stb, joy_lx, joy_ly, joy_rx, joy_ry, recal,
        output cal_busy, joy_up, joy_down, joy_left, joy_right
    );
endinterface

// File: rtl/analog_stick_calibrator.sv
// Learns the rest center of both analog sticks after a settle period, then converts
// stick deflection into DPAD directions with deadzone, hysteresis and SOCD cleaning.
module analog_stick_calibrator #(
    parameter logic [7:0]  DEADZONE      = 8'h10,
    parameter logic [7:0]  HYST          = 8'h04,
    parameter logic [15:0] SETTLE_CYCLES = 16'd1024,
    parameter int unsigned AVG_LOG2      = 4
) (
    input logic                      clk_sys,
    input logic                      reset_n,
    analog_stick_calibrator_if.slave bus
);

    localparam int unsigned ACC_W      = 8 + AVG_LOG2;
    localparam logic [3:0]  PAD_ANALOG = 4'h3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_ACCUM,
        S_RUN
    } state_t;

    state_t state, state_nx;

    logic [15:0]                settle_cnt, settle_nx;
    logic [AVG_LOG2-1:0]        samp_cnt, samp_nx;
    logic [3:0][ACC_W-1:0]      acc, acc_nx;
    logic [3:0][7:0]            center, center_nx;
    logic [3:0]                 neg_f, neg_nx;
    logic [3:0]                 pos_f, pos_nx;
    logic [3:0][7:0]            joy;
    logic [3:0][7:0]            lo, hi, lo_rel, hi_rel;
    logic                       up_q, down_q, left_q, right_q;
    logic                       l_any, r_any, u_any, d_any;

    // Axis order: 0 = LX, 1 = LY, 2 = RX, 3 = RY; neg = left/up, pos = right/down.
    assign joy = {bus.joy_ry, bus.joy_rx, bus.joy_ly, bus.joy_lx};

    function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

    function automatic logic [7:0] sat_sub(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] d;
        d = {1'b0, a} - {1'b0, b};
        return d[8] ? 8'h00 : d[7:0];
    endfunction

    always_comb begin
        for (int unsigned i = 0; i < 4; i++) begin
            lo[i]     = sat_sub(center[i], DEADZONE);
            hi[i]     = sat_add(center[i], DEADZONE);
            lo_rel[i] = sat_add(lo[i], HYST);
            hi_rel[i] = sat_sub(hi[i], HYST);
        end
    end

    always_comb begin
        state_nx  = state;
        settle_nx = settle_cnt;
        samp_nx   = samp_cnt;
        acc_nx    = acc;
        center_nx = center;
        neg_nx    = neg_f;
        pos_nx    = pos_f;

        // Pad loss beats recal, and both swallow any coincident strobe.
        if (bus.pad_type != PAD_ANALOG) begin
            state_nx = S_IDLE;
            neg_nx   = '0;
            pos_nx   = '0;
        end else if (bus.recal && state != S_IDLE) begin
            state_nx  = S_SETTLE;
            settle_nx = '0;
            samp_nx   = '0;
            acc_nx    = '0;
            neg_nx    = '0;
            pos_nx    = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    state_nx  = S_SETTLE;
                    settle_nx = '0;
                end
                S_SETTLE: begin
                    if (settle_cnt == SETTLE_CYCLES - 16'd1) begin
                        state_nx = S_ACCUM;
                        acc_nx   = '0;
                        samp_nx  = '0;
                    end else begin
                        settle_nx = settle_cnt + 16'd1;
                    end
                end
                S_ACCUM: begin
                    if (bus.sample_stb) begin
                        for (int unsigned i = 0; i < 4; i++) begin
                            acc_nx[i] = acc[i] + ACC_W'(joy[i]);
                        end
                        samp_nx = samp_cnt + 1'b1;
                        if (samp_cnt == '1) begin
                            for (int unsigned i = 0; i < 4; i++) begin
                                center_nx[i] = acc_nx[i][ACC_W-1:AVG_LOG2];
                            end
                            state_nx = S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (bus.sample_stb) begin
                        for (int unsigned i = 0; i < 4; i++) begin
                            if (joy[i] < lo[i])
                                neg_nx[i] = 1'b1;
                            else if (joy[i] >= lo_rel[i])
                                neg_nx[i] = 1'b0;
                            if (joy[i] > hi[i])
                                pos_nx[i] = 1'b1;
                            else if (joy[i] <= hi_rel[i])
                                pos_nx[i] = 1'b0;
                        end
                    end
                end
                default: state_nx = S_IDLE;
            endcase
        end
    end

    always_comb begin
        l_any = neg_nx[0] | neg_nx[2];
        r_any = pos_nx[0] | pos_nx[2];
        u_any = neg_nx[1] | neg_nx[3];
        d_any = pos_nx[1] | pos_nx[3];
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            settle_cnt <= '0;
            samp_cnt   <= '0;
            acc        <= '0;
            center     <= {4{8'h80}};
            neg_f      <= '0;
            pos_f      <= '0;
            up_q       <= 1'b0;
            down_q     <= 1'b0;
            left_q     <= 1'b0;
            right_q    <= 1'b0;
        end else begin
            state      <= state_nx;
            settle_cnt <= settle_nx;
            samp_cnt   <= samp_nx;
            acc        <= acc_nx;
            center     <= center_nx;
            neg_f      <= neg_nx;
            pos_f      <= pos_nx;
            left_q     <= (state_nx == S_RUN) && l_any && !r_any;
            right_q    <= (state_nx == S_RUN) && r_any && !l_any;
            up_q       <= (state_nx == S_RUN) && u_any && !d_any;
            down_q     <= (state_nx == S_RUN) && d_any && !u_any;
        end
    end

    assign bus.cal_busy  = (state == S_SETTLE) || (state == S_ACCUM);
    assign bus.joy_up    = up_q;
    assign bus.joy_down  = down_q;
    assign bus.joy_left  = left_q;
    assign bus.joy_right = right_q;

endmodule

// File: tb/tb_analog_stick_calibrator.sv
// Scoreboard bench: each strobe queues its expected DPAD/busy response, which a
// separate monitor compares one cycle after the strobe is sampled.
module tb_analog_stick_calibrator;

    logic clk_sys = 1'b0;
    logic reset_n;

    analog_stick_calibrator_if bus();

    analog_stick_calibrator #(
        .SETTLE_CYCLES(16'd8),
        .AVG_LOG2(2)
    ) dut (
        .clk_sys(clk_sys),
        .reset_n(reset_n),
        .bus(bus)
    );

    always #5 clk_sys = ~clk_sys;

    // Expected response encoding: {up, down, left, right, busy}
    localparam logic [4:0] NONE  = 5'b00000;
    localparam logic [4:0] BUSY  = 5'b00001;
    localparam logic [4:0] RIGHT = 5'b00010;
    localparam logic [4:0] LEFT  = 5'b00100;
    localparam logic [4:0] UP    = 5'b10000;

    logic [4:0] exp_q[$];
    string      name_q[$];
    int         tests;
    int         fails;

    function automatic logic [4:0] observed();
        return {bus.joy_up, bus.joy_down, bus.joy_left, bus.joy_right, bus.cal_busy};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic step();
        @(negedge clk_sys);
    endtask

    task automatic strobe(input string name, input logic [7:0] lx, input logic [7:0] ly,
                          input logic [7:0] rx, input logic [7:0] ry, input logic [4:0] e);
        bus.joy_lx     = lx;
        bus.joy_ly     = ly;
        bus.joy_rx     = rx;
        bus.joy_ry     = ry;
        bus.sample_stb = 1'b1;
        exp_q.push_back(e);
        name_q.push_back(name);
        step();
        bus.sample_stb = 1'b0;
    endtask

    // Monitor: a strobe sampled on a rising edge is reflected by the next falling edge.
    initial begin
        forever begin
            logic       s;
            logic [4:0] e;
            string      n;
            @(posedge clk_sys);
            s = bus.sample_stb;
            @(negedge clk_sys);
            if (s) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL stray_response: got %b, expected no response", observed());
                end else begin
                    e = exp_q.pop_front();
                    n = name_q.pop_front();
                    check(n, 32'(observed()), 32'(e));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tests          = 0;
        fails          = 0;
        reset_n        = 1'b0;
        bus.pad_type   = 4'h0;
        bus.sample_stb = 1'b0;
        bus.recal      = 1'b0;
        bus.joy_lx     = 8'h80;
        bus.joy_ly     = 8'h80;
        bus.joy_rx     = 8'h80;
        bus.joy_ry     = 8'h80;
        repeat (3) step();
        reset_n = 1'b1;
        step();
        check("reset_outputs", 32'(observed()), 32'(NONE));
        check("reset_centers", 32'(dut.center), 32'h80808080);

        // First calibration: LX rests at 0x90
        bus.pad_type = 4'h3;
        step();
        check("busy_after_pad", 32'(bus.cal_busy), 32'd1);
        repeat (7) step();
        strobe("settle_strobe_ignored", 8'h00, 8'h80, 8'h80, 8'h80, BUSY);
        strobe("cal1_s1", 8'h90, 8'h80, 8'h80, 8'h80, BUSY);
        strobe("cal1_s2", 8'h90, 8'h80, 8'h80, 8'h80, BUSY);
        strobe("cal1_s3", 8'h90, 8'h80, 8'h80, 8'h80, BUSY);
        strobe("cal1_s4_done", 8'h90, 8'h80, 8'h80, 8'h80, NONE);
        check("cal1_centers", 32'(dut.center), 32'h80808090);
        strobe("lx80_neutral", 8'h80, 8'h80, 8'h80, 8'h80, NONE);
        strobe("lx7f_left", 8'h7F, 8'h80, 8'h80, 8'h80, LEFT);

        // Recal with a coincident strobe (discarded), then calibrate to 0x80
        bus.recal = 1'b1;
        strobe("recal_discard", 8'h00, 8'h80, 8'h80, 8'h80, BUSY);
        bus.recal = 1'b0;
        repeat (7) step();
        strobe("settle_strobe_ignored2", 8'h00, 8'h00, 8'h00, 8'h00, BUSY);
        strobe("cal2_s1", 8'h80, 8'h80, 8'h80, 8'h80, BUSY);
        strobe("cal2_s2", 8'h80, 8'h80, 8'h80, 8'h80, BUSY);
        strobe("cal2_s3", 8'h80, 8'h80, 8'h80, 8'h80, BUSY);
        strobe("cal2_s4_done", 8'h80, 8'h80, 8'h80, 8'h80, NONE);

        // Hysteresis: lo=0x70 lo_rel=0x74 hi=0x90 hi_rel=0x8C
        strobe("hyst_6f_left", 8'h6F, 8'h80, 8'h80, 8'h80, LEFT);
        strobe("hyst_72_hold", 8'h72, 8'h80, 8'h80, 8'h80, LEFT);
        strobe("hyst_74_release", 8'h74, 8'h80, 8'h80, 8'h80, NONE);
        strobe("hyst_91_right", 8'h91, 8'h80, 8'h80, 8'h80, RIGHT);
        strobe("hyst_8c_release", 8'h8C, 8'h80, 8'h80, 8'h80, NONE);

        // SOCD: left stick left, right stick right, left stick up
        strobe("socd_lr_cancel_up", 8'h00, 8'h00, 8'hFF, 8'h80, UP);
        strobe("socd_neutral", 8'h80, 8'h80, 8'h80, 8'h80, NONE);

        // Abort mid-ACCUM by pad loss
        bus.recal = 1'b1;
        step();
        bus.recal = 1'b0;
        repeat (7) step();
        strobe("settle_strobe_ignored3", 8'h80, 8'h80, 8'h80, 8'h80, BUSY);
        strobe("abort_s1", 8'h20, 8'h80, 8'h80, 8'h80, BUSY);
        strobe("abort_s2", 8'h20, 8'h80, 8'h80, 8'h80, BUSY);
        bus.pad_type = 4'h0;
        step();
        check("abort_outputs", 32'(observed()), 32'(NONE));
        check("abort_center_lx", 32'(dut.center[0]), 32'h80);

        // Restart: SETTLE lasts exactly 8 cycles
        bus.pad_type = 4'h3;
        for (int i = 0; i < 8; i++) begin
            step();
            check($sformatf("settle_busy_c%0d", i + 1), 32'(bus.cal_busy), 32'd1);
        end
        strobe("settle_last_ignored", 8'hFF, 8'hFF, 8'hFF, 8'hFF, BUSY);

        // Saturation: centers 0x08 (LX average truncates 0x23>>2), lo=0x00 hi=0x18
        strobe("cal3_s1", 8'h08, 8'h08, 8'h08, 8'h08, BUSY);
        strobe("cal3_s2", 8'h08, 8'h08, 8'h08, 8'h08, BUSY);
        strobe("cal3_s3", 8'h08, 8'h08, 8'h08, 8'h08, BUSY);
        strobe("cal3_s4_done", 8'h0B, 8'h08, 8'h08, 8'h08, NONE);
        check("cal3_centers", 32'(dut.center), 32'h08080808);
        strobe("sat_00_no_left", 8'h00, 8'h00, 8'h08, 8'h08, NONE);
        strobe("sat_18_no_right", 8'h18, 8'h08, 8'h08, 8'h08, NONE);
        strobe("sat_19_right", 8'h19, 8'h08, 8'h08, 8'h08, RIGHT);
        strobe("sat_08_release", 8'h08, 8'h08, 8'h08, 8'h08, NONE);

        // Back to 0x80 centers, assert left, then async reset
        bus.recal = 1'b1;
        step();
        bus.recal = 1'b0;
        repeat (7) step();
        strobe("settle_strobe_ignored4", 8'h80, 8'h80, 8'h80, 8'h80, BUSY);
        strobe("cal4_s1", 8'h80, 8'h80, 8'h80, 8'h80, BUSY);
        strobe("cal4_s2", 8'h80, 8'h80, 8'h80, 8'h80, BUSY);
        strobe("cal4_s3", 8'h80, 8'h80, 8'h80, 8'h80, BUSY);
        strobe("cal4_s4_done", 8'h80, 8'h80, 8'h80, 8'h80, NONE);
        strobe("pre_reset_left", 8'h6F, 8'h80, 8'h80, 8'h80, LEFT);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset_outputs", 32'(observed()), 32'(NONE));
        step();
        reset_n = 1'b1;
        check("post_reset_centers", 32'(dut.center), 32'h80808080);
        step();
        check("post_reset_busy", 32'(bus.cal_busy), 32'd1);

        repeat (2) step();
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
